// File: rtl/calc_menu_pkg.sv
// Shared encodings for the calculator menu sequencer.
// Pure declarations, no latency.
// No flow control here.
package calc_menu_pkg;

  // FSM state encodings (also driven out as state_code for the display)
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_LOAD_A = 3'd2,
    ST_LOAD_B = 3'd3,
    ST_ISSUE  = 3'd4,
    ST_WAIT   = 3'd5,
    ST_SHOW   = 3'd6,
    ST_ERROR  = 3'd7
  } state_t;

  // Button bit positions in the btn pulse vector
  localparam int BTN_CONFIRM = 0;
  localparam int BTN_BACK    = 1;
  localparam int BTN_NEXT    = 2;
  localparam int BTN_PREV    = 3;

  // Operation codes carried on cmd_mode
  localparam logic [1:0] MODE_ADD = 2'd0;
  localparam logic [1:0] MODE_SUB = 2'd1;
  localparam logic [1:0] MODE_MUL = 2'd2;
  localparam logic [1:0] MODE_NEG = 2'd3;

  // The single button action that wins in a cycle
  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_BACK,
    ACT_CONFIRM,
    ACT_NEXT,
    ACT_PREV
  } btn_act_t;

  // Simultaneous pulses resolve as BACK > CONFIRM > NEXT > PREV
  function automatic btn_act_t resolve_btn(input logic [3:0] btn);
    btn_act_t act;
    act = ACT_NONE;
    if (btn[BTN_BACK])         act = ACT_BACK;
    else if (btn[BTN_CONFIRM]) act = ACT_CONFIRM;
    else if (btn[BTN_NEXT])    act = ACT_NEXT;
    else if (btn[BTN_PREV])    act = ACT_PREV;
    return act;
  endfunction

endpackage

// File: rtl/calc_menu_ctrl_wait_timer.sv
// Response timeout counter: clears to zero, counts while enabled, flags the last cycle.
// expired is combinational from the registered count (same cycle as count reaches TIMEOUT_CYC-1).
// No handshake; the counter parks at the terminal value until cleared.
module wait_timer #(
  parameter int TIMEOUT_CYC = 50_000,
  parameter int TMR_W       = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYC - 1);

  logic [TMR_W-1:0] count;

  assign expired = (count == LAST);

  // Count up while enabled; holding at LAST keeps expired stable if the owner lingers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/calc_menu_ctrl.sv
// Menu/command sequencer: button-driven mode and operand entry, one command per transaction.
// Button effects visible one cycle after the pulse edge; result/SHOW one cycle after rsp_valid.
// cmd_valid holds with stable payload until cmd_ready; response wait bounded by TIMEOUT_CYC.
module calc_menu_ctrl
  import calc_menu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50_000,
  parameter int TMR_W       = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  btn,
  input  logic [7:0]  sw,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [1:0]  cmd_mode,
  output logic [7:0]  cmd_a,
  output logic [7:0]  cmd_b,
  input  logic        rsp_valid,
  input  logic [15:0] rsp_data,
  output logic [15:0] result,
  output logic [1:0]  mode_sel,
  output logic [2:0]  state_code,
  output logic        error
);

  state_t   state;
  btn_act_t act;
  logic     tmr_expired;

  assign act        = resolve_btn(btn);
  assign state_code = state;

  // Timer is held at zero outside WAIT, so it starts from zero on every WAIT entry
  wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TMR_W       (TMR_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state != ST_WAIT),
    .en      (state == ST_WAIT),
    .expired (tmr_expired)
  );

  // Menu FSM with registered command, result and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mode_sel  <= 2'd0;
      cmd_mode  <= MODE_ADD;
      cmd_a     <= 8'd0;
      cmd_b     <= 8'd0;
      cmd_valid <= 1'b0;
      result    <= 16'd0;
      error     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (act == ACT_CONFIRM) state <= ST_SELECT;
        end
        ST_SELECT: begin
          case (act)
            ACT_BACK:    state <= ST_IDLE;
            ACT_CONFIRM: begin
              cmd_mode <= mode_sel;
              state    <= ST_LOAD_A;
            end
            ACT_NEXT:    mode_sel <= mode_sel + 2'd1;
            ACT_PREV:    mode_sel <= mode_sel - 2'd1;
            default:     ;
          endcase
        end
        ST_LOAD_A: begin
          if (act == ACT_BACK) begin
            state <= ST_SELECT;
          end else if (act == ACT_CONFIRM) begin
            cmd_a <= sw;
            // Unary op: no second operand, go straight to issue
            if (cmd_mode == MODE_NEG) begin
              cmd_b     <= 8'd0;
              cmd_valid <= 1'b1;
              state     <= ST_ISSUE;
            end else begin
              state <= ST_LOAD_B;
            end
          end
        end
        ST_LOAD_B: begin
          if (act == ACT_BACK) begin
            state <= ST_LOAD_A;
          end else if (act == ACT_CONFIRM) begin
            cmd_b     <= sw;
            cmd_valid <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Buttons ignored; valid only drops on a completed transfer
          if (cmd_valid && cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A response in the timeout cycle still counts
          if (rsp_valid) begin
            result <= rsp_data;
            state  <= ST_SHOW;
          end else if (tmr_expired) begin
            error <= 1'b1;
            state <= ST_ERROR;
          end
        end
        ST_SHOW: begin
          if (act == ACT_BACK)         state <= ST_IDLE;
          else if (act == ACT_CONFIRM) state <= ST_SELECT;
        end
        ST_ERROR: begin
          if (act == ACT_BACK || act == ACT_CONFIRM) begin
            error <= 1'b0;
            state <= ST_SELECT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_menu_ctrl.sv
// Bench for calc_menu_ctrl: transaction-level model checked every cycle plus directed literal checks.
module tb_calc_menu_ctrl;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  btn;
  logic [7:0]  sw;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_mode;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [15:0] result;
  logic [1:0]  mode_sel;
  logic [2:0]  state_code;
  logic        error;

  int vectors     = 0;
  int miscompares = 0;

  calc_menu_ctrl #(.TIMEOUT_CYC(T), .TMR_W(20)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn        (btn),
    .sw         (sw),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mode   (cmd_mode),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .result     (result),
    .mode_sel   (mode_sel),
    .state_code (state_code),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // States by number: 0 idle,1 select,2 load A,3 load B,4 issue,5 wait,6 show,7 error
  int          m_st, m_sel, m_mode, cyc, t_entry;
  logic [7:0]  m_a, m_b;
  logic [15:0] m_res;

  // 0 none, 1 back, 2 confirm, 3 next, 4 prev
  function automatic int winner(input logic [3:0] b);
    if (b[1]) return 1;
    if (b[0]) return 2;
    if (b[2]) return 3;
    if (b[3]) return 4;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int w;
    if (!rst_n) begin
      m_st = 0; m_sel = 0; m_mode = 0; m_a = 0; m_b = 0; m_res = 0;
      cyc = 0; t_entry = 0;
    end else begin
      cyc++;
      w = winner(btn);
      case (m_st)
        0: if (w == 2) m_st = 1;
        1: begin
          if (w == 1) m_st = 0;
          else if (w == 2) begin m_mode = m_sel; m_st = 2; end
          else if (w == 3) m_sel = (m_sel + 1) % 4;
          else if (w == 4) m_sel = (m_sel + 3) % 4;
        end
        2: begin
          if (w == 1) m_st = 1;
          else if (w == 2) begin
            m_a = sw;
            if (m_mode == 3) begin m_b = 0; m_st = 4; end
            else m_st = 3;
          end
        end
        3: begin
          if (w == 1) m_st = 2;
          else if (w == 2) begin m_b = sw; m_st = 4; end
        end
        4: if (cmd_ready) begin m_st = 5; t_entry = cyc; end
        5: begin
          if (rsp_valid) begin m_res = rsp_data; m_st = 6; end
          else if (cyc - t_entry == T) m_st = 7;
        end
        6: begin
          if (w == 1) m_st = 0;
          else if (w == 2) m_st = 1;
        end
        default: if (w == 1 || w == 2) m_st = 1;
      endcase
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check("state_code", state_code, m_st);
    check("mode_sel",   mode_sel,   m_sel);
    check("cmd_mode",   cmd_mode,   m_mode);
    check("cmd_a",      cmd_a,      m_a);
    check("cmd_b",      cmd_b,      m_b);
    check("cmd_valid",  cmd_valid,  (m_st == 4) ? 1 : 0);
    check("result",     result,     m_res);
    check("error",      error,      (m_st == 7) ? 1 : 0);
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] b);
    btn = b;
    tick();
    btn = 4'd0;
  endtask

  localparam logic [3:0] CONF = 4'b0001;
  localparam logic [3:0] BACK = 4'b0010;
  localparam logic [3:0] NEXT = 4'b0100;
  localparam logic [3:0] PREV = 4'b1000;

  initial begin
    int nvalid;
    int n;
    rst_n = 1'b0; btn = 4'd0; sw = 8'd0; cmd_ready = 1'b0;
    rsp_valid = 1'b0; rsp_data = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", state_code, 0);
    check("rst_valid", cmd_valid, 0);
    check("rst_result", result, 0);
    rst_n = 1'b1;
    tick();

    // Mode selection wrap
    press(NEXT);                      // ignored in IDLE
    press(CONF);
    check("enter_select", state_code, 1);
    repeat (5) press(NEXT);
    check("next_x5", mode_sel, 1);
    repeat (2) press(PREV);
    check("prev_x2", mode_sel, 3);

    // ADD 0x12 + 0x34 with ready held off for 3 cycles
    press(NEXT);                      // 3 -> 0
    press(CONF);
    sw = 8'h12; press(CONF);
    sw = 8'h34; press(CONF);
    nvalid = 0;
    for (int i = 0; i < 6; i++) begin
      if (cmd_valid) begin
        nvalid++;
        check("add_a_stable", cmd_a, 8'h12);
        check("add_b_stable", cmd_b, 8'h34);
      end
      cmd_ready = (i == 3);
      tick();
    end
    cmd_ready = 1'b0;
    check("valid_width", nvalid, 4);
    check("in_wait", state_code, 5);
    rsp_valid = 1'b1; rsp_data = 16'h0046;
    tick();
    rsp_valid = 1'b0;
    check("add_result", result, 16'h0046);
    check("add_show", state_code, 6);

    // NEG skips operand B
    press(CONF);                      // SHOW -> SELECT
    press(PREV);                      // 0 -> 3
    press(CONF);
    sw = 8'h05; press(CONF);
    check("neg_issue", state_code, 4);
    check("neg_valid", cmd_valid, 1);
    check("neg_b_zero", cmd_b, 0);
    check("neg_a", cmd_a, 8'h05);
    cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;

    // Timeout with no response
    n = 0;
    while (state_code != 3'd7 && n < 20) begin
      tick();
      n++;
    end
    check("timeout_cycles", n, T);
    check("timeout_error", error, 1);
    rsp_valid = 1'b1; rsp_data = 16'hBEEF;
    tick();
    rsp_valid = 1'b0;
    check("late_rsp_result", result, 16'h0046);
    check("late_rsp_state", state_code, 7);
    press(CONF);
    check("err_exit_state", state_code, 1);
    check("err_exit_flag", error, 0);

    // Simultaneous CONFIRM+BACK in LOAD_B, then response on the timeout cycle
    press(NEXT);                      // 3 -> 0
    press(CONF);
    sw = 8'h21; press(CONF);
    press(CONF | BACK);
    check("back_wins", state_code, 2);
    check("back_keeps_a", cmd_a, 8'h21);
    press(CONF);
    sw = 8'h03; press(CONF);
    cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
    repeat (T - 1) tick();
    check("still_wait", state_code, 5);
    rsp_valid = 1'b1; rsp_data = 16'h0024;
    tick();
    rsp_valid = 1'b0;
    check("coincident_show", state_code, 6);
    check("coincident_result", result, 16'h0024);

    // Asynchronous reset while a command is offered
    press(NEXT);                      // ignored in SHOW
    press(CONF);
    press(NEXT);                      // 0 -> 1 (SUB)
    press(CONF);
    sw = 8'h44; press(CONF);
    sw = 8'h55; press(CONF);
    check("pre_rst_valid", cmd_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", cmd_valid, 0);
    check("arst_state", state_code, 0);
    check("arst_mode_sel", mode_sel, 0);
    check("arst_cmd_mode", cmd_mode, 0);
    check("arst_a", cmd_a, 0);
    check("arst_b", cmd_b, 0);
    check("arst_result", result, 0);
    check("arst_error", error, 0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/calc_menu_ctrl.md
# calc_menu_ctrl

Menu and command sequencer sitting between the debounced board inputs and the arithmetic unit. It consumes one-cycle button pulses and stable switch levels, walks the user through mode selection and operand entry, and issues one command per transaction over a valid/ready handshake. It then waits for the response with a timeout and holds the result and status for the display logic.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 50_000: cycles allowed in WAIT before ERROR, legal range 2..2^20-1.
- `TMR_W`, default 20: timeout counter width.

Ports:
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `btn` input 4: one-cycle pulses. Bit 0 CONFIRM, bit 1 BACK, bit 2 NEXT, bit 3 PREV.
- `sw` input 8: stable debounced switch levels, used as the operand value.
- `cmd_valid` output 1: command offered.
- `cmd_ready` input 1: the arithmetic unit accepts the command.
- `cmd_mode` output 2: operation. 0 ADD, 1 SUB, 2 MUL, 3 NEG (unary).
- `cmd_a` output 8: operand A.
- `cmd_b` output 8: operand B. Forced to 0 for NEG.
- `rsp_valid` input 1: one-cycle response strobe.
- `rsp_data` input 16: result.
- `result` output 16: last captured result.
- `mode_sel` output 2: currently highlighted mode.
- `state_code` output 3: current FSM state, for the display.
- `error` output 1: high while in ERROR.

## Operation
- States and encodings: IDLE=0, SELECT=1, LOAD_A=2, LOAD_B=3, ISSUE=4, WAIT=5, SHOW=6, ERROR=7.
- Button priority when several pulses arrive in the same cycle: BACK > CONFIRM > NEXT > PREV. Only the winner acts.
- IDLE: CONFIRM moves to SELECT. All other buttons are ignored.
- SELECT:
  - NEXT increments `mode_sel` modulo 4 (3 wraps to 0).
  - PREV decrements it modulo 4 (0 wraps to 3).
  - CONFIRM latches `mode_sel` into `cmd_mode` and moves to LOAD_A.
  - BACK moves to IDLE.
- LOAD_A: CONFIRM latches `sw` into `cmd_a`. The next state is LOAD_B, or ISSUE if `cmd_mode`=NEG, in which case `cmd_b` is cleared to 0. BACK returns to SELECT.
- LOAD_B: CONFIRM latches `sw` into `cmd_b` and moves to ISSUE. BACK returns to LOAD_A; the value in `cmd_a` is kept.
- ISSUE:
  - `cmd_valid`=1. `cmd_mode`, `cmd_a` and `cmd_b` are stable while valid is high.
  - All buttons are ignored; valid is never withdrawn without a transfer.
  - A transfer occurs on a clock edge where `cmd_valid`&&`cmd_ready`; the state then moves to WAIT.
- WAIT:
  - A timer clears on entry and increments every cycle.
  - `rsp_valid` moves to SHOW and latches `rsp_data` into `result`.
  - If the timer reaches `TIMEOUT_CYC`-1 without `rsp_valid`, the state moves to ERROR.
  - If `rsp_valid` arrives in the same cycle as the timeout, the response wins.
  - Buttons are ignored.
- SHOW: `result` is held. CONFIRM moves to SELECT (new transaction). BACK moves to IDLE.
- ERROR: `error`=1 and `result` is unchanged. CONFIRM or BACK moves to SELECT and clears `error`.
- `rsp_valid` outside WAIT is ignored. A late response after a timeout is discarded.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `state_code`=0, `mode_sel`=0, `cmd_mode`=0, `cmd_a`=0, `cmd_b`=0, `cmd_valid`=0, `result`=0, `error`=0, timer=0.
- A button pulse at edge t changes state and latched values, visible after t.
- `cmd_valid` rises in the first cycle the state is ISSUE. It falls in the cycle after the transfer edge. If `cmd_ready` is already high, the minimum valid width is 1 cycle.
- Response latency:
  - `result` and `state_code`=SHOW update one cycle after the `rsp_valid` edge.
  - Timeout: ERROR is entered exactly `TIMEOUT_CYC` cycles after entering WAIT.
- Reset mid-transaction (including during ISSUE with valid high) returns immediately and asynchronously to the reset values. Downstream must tolerate valid dropping on reset.

## Structure
- Package `calc_menu_pkg` holds:
  - State encodings.
  - Button bit indices (`BTN_CONFIRM`=0, `BTN_BACK`=1, `BTN_NEXT`=2, `BTN_PREV`=3).
  - Mode codes (ADD/SUB/MUL/NEG).
- Sub-module `wait_timer`: loadable up-counter with `clear`, `en` and `expired` (asserted when count = `TIMEOUT_CYC`-1). The FSM, operand registers and handshake stay in the top module.

## Test plan
- Reset, CONFIRM, then NEXT×5 -> `mode_sel`=1 (wraps through 3→0). Then PREV×2 -> `mode_sel`=3.
- ADD, A=0x12, B=0x34, `cmd_ready` held low 3 cycles -> `cmd_valid` high for 4 cycles with operands stable, one transfer. `rsp_valid` with 0x0046 -> `result`=0x0046, `state_code`=6.
- NEG, A=0x05 -> LOAD_B skipped, `cmd_b`=0, `cmd_valid` high the cycle after CONFIRM.
- `TIMEOUT_CYC`=8, no response -> ERROR exactly 8 cycles after WAIT entry, `error`=1. Later `rsp_valid` ignored, `result` unchanged. CONFIRM -> SELECT, `error`=0.
- CONFIRM and BACK pulsed in the same cycle in LOAD_B -> LOAD_A. Response coincident with the timeout cycle -> SHOW, not ERROR.
- `rst_n` low while `cmd_valid`=1 -> all outputs at reset values without waiting for a clock edge.
